// File: rtl/pulse_ctrl_pkg.sv
// Shared encodings for the pulse parameter command decoder: FSM states, control-byte
// fields, the NAK byte and the 8-bit wrapping checksum used in every response.
package pulse_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RECV,
    ST_EXEC,
    ST_TX_LOAD,
    ST_TX_HOLD,
    ST_TX_WAIT
  } state_t;

  localparam int         CTRL_RD_BIT = 7;
  localparam logic [6:0] ADDR_COMMIT = 7'h7F;
  localparam logic [7:0] NAK_BYTE    = 8'hEE;

  // Wrapping sum of the low nbytes bytes of data.
  function automatic logic [7:0] checksum(input logic [63:0] data, input int nbytes);
    logic [7:0] sum;
    sum = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < nbytes) sum = sum + data[8*i +: 8];
    end
    return sum;
  endfunction

endpackage

// File: rtl/pulse_frame_rx.sv
// Frame assembler: collects DATA_BYTES payload bytes plus a control byte, discards
// partial frames on inter-byte timeout or framing error and counts those discards.
module pulse_frame_rx #(
  parameter int DATA_BYTES  = 4,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_en,
  input  logic                    rx_received,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_error,
  output logic                    o_frame_valid,
  output logic                    o_byte_acc,
  output logic                    o_discard,
  output logic [8*DATA_BYTES-1:0] o_payload,
  output logic [7:0]              o_ctrl,
  output logic [7:0]              o_err_cnt
);

  localparam int CNT_W = $clog2(DATA_BYTES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0]        r_cnt;
  logic [TMO_W-1:0]        r_idle;
  logic [8*DATA_BYTES-1:0] r_payload;
  logic [7:0]              r_ctrl;
  logic [7:0]              r_err_cnt;
  logic                    w_timeout;

  assign w_timeout     = (r_cnt != '0) && !rx_received && (r_idle == TMO_W'(TIMEOUT_CYC - 1));
  assign o_discard     = i_en && (rx_error || w_timeout);
  assign o_byte_acc    = i_en && rx_received && !o_discard;
  // Combinational so the top FSM can enter EXEC on the same edge the control byte lands.
  assign o_frame_valid = o_byte_acc && (r_cnt == CNT_W'(DATA_BYTES));
  assign o_payload     = r_payload;
  assign o_ctrl        = r_ctrl;
  assign o_err_cnt     = r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_idle    <= '0;
      r_payload <= '0;
      r_ctrl    <= '0;
      r_err_cnt <= '0;
    end else begin
      if (o_discard) begin
        r_cnt  <= '0;
        r_idle <= '0;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end else if (o_byte_acc) begin
        r_idle <= '0;
        if (o_frame_valid) begin
          r_ctrl <= rx_byte;
          r_cnt  <= '0;
        end else begin
          for (int i = 0; i < DATA_BYTES; i++) begin
            if (r_cnt == CNT_W'(i)) r_payload[8*i +: 8] <= rx_byte;
          end
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else if (r_cnt != '0) begin
        r_idle <= r_idle + TMO_W'(1);
      end
    end
  end

endmodule

// File: rtl/pulse_param_regfile.sv
// UART command decoder for NUM_REGS pulse-timing registers with write/read/NAK responses.
// Define PULSE_SHADOW_COMMIT_EN to stage writes in shadow regs applied by address 0x7F.
module pulse_param_regfile
  import pulse_ctrl_pkg::*;
#(
  parameter int                        NUM_REGS    = 8,
  parameter int                        REG_W       = 32,
  parameter int                        DATA_BYTES  = 4,
  parameter int                        TIMEOUT_CYC = 1_000_000,
  parameter logic [NUM_REGS*REG_W-1:0] INIT_VALS   = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_received,
  input  logic [7:0]                rx_byte,
  input  logic                      rx_error,
  input  logic                      is_transmitting,
  output logic                      transmit,
  output logic [7:0]                tx_byte,
  output logic [NUM_REGS*REG_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]       upd_stb,
  output logic                      busy,
  output logic [7:0]                err_cnt
);

  localparam int PL_W  = 8 * DATA_BYTES;
  localparam int RSP_W = 8 * (DATA_BYTES + 1);
  localparam int IDX_W = 4;

  state_t                    r_state;
  logic [RSP_W-1:0]          r_resp;
  logic [IDX_W-1:0]          r_len;
  logic [IDX_W-1:0]          r_idx;
  logic                      w_frame_valid;
  logic                      w_byte_acc;
  logic                      w_discard;
  logic [PL_W-1:0]           w_payload;
  logic [7:0]                w_ctrl;
  logic [6:0]                w_addr;
  logic                      w_is_rd;
  logic                      w_addr_ok;
  logic                      w_is_commit;
  logic                      w_exec_wr;
  logic [NUM_REGS*REG_W-1:0] w_rd_flat;
  logic [REG_W-1:0]          w_rd_val;
  logic [PL_W-1:0]           w_rd_ext;
  logic [7:0]                w_cur_byte;

  pulse_frame_rx #(
    .DATA_BYTES  (DATA_BYTES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame_rx (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_en          (r_state == ST_RECV),
    .rx_received   (rx_received),
    .rx_byte       (rx_byte),
    .rx_error      (rx_error),
    .o_frame_valid (w_frame_valid),
    .o_byte_acc    (w_byte_acc),
    .o_discard     (w_discard),
    .o_payload     (w_payload),
    .o_ctrl        (w_ctrl),
    .o_err_cnt     (err_cnt)
  );

  assign w_addr    = w_ctrl[6:0];
  assign w_is_rd   = w_ctrl[CTRL_RD_BIT];
  assign w_addr_ok = (int'(w_addr) < NUM_REGS);
  assign w_exec_wr = (r_state == ST_EXEC) && !w_is_rd && w_addr_ok;
`ifdef PULSE_SHADOW_COMMIT_EN
  assign w_is_commit = (w_addr == ADDR_COMMIT);
`else
  assign w_is_commit = 1'b0;
`endif

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [REG_W-1:0] r_live;
    logic             r_upd;
    logic             w_sel;

    assign w_sel = (w_addr == 7'(gi));

`ifdef PULSE_SHADOW_COMMIT_EN
    logic [REG_W-1:0] r_shadow;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_shadow <= INIT_VALS[gi*REG_W +: REG_W];
        r_live   <= INIT_VALS[gi*REG_W +: REG_W];
        r_upd    <= 1'b0;
      end else begin
        r_upd <= 1'b0;
        if (w_exec_wr && w_sel) r_shadow <= w_payload[REG_W-1:0];
        if ((r_state == ST_EXEC) && w_is_commit) begin
          r_live <= r_shadow;
          r_upd  <= (r_live != r_shadow);
        end
      end
    end

    assign w_rd_flat[gi*REG_W +: REG_W] = r_shadow;
`else
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_live <= INIT_VALS[gi*REG_W +: REG_W];
        r_upd  <= 1'b0;
      end else begin
        r_upd <= 1'b0;
        if (w_exec_wr && w_sel) begin
          r_live <= w_payload[REG_W-1:0];
          r_upd  <= 1'b1;
        end
      end
    end

    assign w_rd_flat[gi*REG_W +: REG_W] = r_live;
`endif

    assign regs_flat[gi*REG_W +: REG_W] = r_live;
    assign upd_stb[gi]                  = r_upd;
  end

  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(w_addr) == i) w_rd_val = w_rd_flat[i*REG_W +: REG_W];
    end
  end

  assign w_rd_ext = PL_W'(w_rd_val);

  always_comb begin
    w_cur_byte = '0;
    for (int i = 0; i <= DATA_BYTES; i++) begin
      if (int'(r_idx) == i) w_cur_byte = r_resp[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RECV;
      r_resp   <= '0;
      r_len    <= '0;
      r_idx    <= '0;
      transmit <= 1'b0;
      tx_byte  <= '0;
      busy     <= 1'b0;
    end else begin
      transmit <= 1'b0;
      case (r_state)
        ST_RECV: begin
          if (w_discard)       busy <= 1'b0;
          else if (w_byte_acc) busy <= 1'b1;
          if (w_frame_valid) r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_idx  <= '0;
          r_len  <= IDX_W'(1);
          r_resp <= '0;
          if (w_is_commit || (!w_is_rd && w_addr_ok)) begin
            r_resp[7:0] <= checksum(64'(w_payload), DATA_BYTES);
          end else if (w_addr_ok) begin
            r_resp <= {checksum(64'(w_rd_ext), DATA_BYTES), w_rd_ext};
            r_len  <= IDX_W'(DATA_BYTES + 1);
          end else begin
            r_resp[7:0] <= NAK_BYTE;
          end
          r_state <= ST_TX_LOAD;
        end
        ST_TX_LOAD: begin
          if (!is_transmitting) begin
            tx_byte  <= w_cur_byte;
            transmit <= 1'b1;
            r_state  <= ST_TX_HOLD;
          end
        end
        // Guard cycle so the uart has time to raise is_transmitting.
        ST_TX_HOLD: r_state <= ST_TX_WAIT;
        ST_TX_WAIT: begin
          if (!is_transmitting) begin
            if (r_idx == r_len - IDX_W'(1)) begin
              r_state <= ST_RECV;
              busy    <= 1'b0;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= ST_TX_LOAD;
            end
          end
        end
        default: r_state <= ST_RECV;
      endcase
    end
  end

endmodule
